// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster generator. A free-running h/v counter pair feeds a
//   two-stage output pipeline:
//     stage 1: x, y, fetch   (fetch coordinates handed to the pixel source)
//     stage 2: hsync, vsync, de, line_start, frame_start, red/green/blue
//   All stage-2 outputs describe the same pixel, so they stay mutually aligned.
//
//   Optional feature macro: VGA_TEST_PATTERN_EN
//     defined   -> pattern_sel selects pix_in / white / colour bars / quadrants
//     undefined -> pattern_sel is ignored, RGB is the registered pix_in
//
// Ports
//   CLK          in   pixel clock
//   RST          in   synchronous active-high reset (wins over en)
//   en           in   clock enable for counters, pipeline and latched pattern
//   pattern_sel  in   0 pix_in, 1 white, 2 colour bars, 3 quadrants
//   pix_in       in   {R,G,B} for the (x,y) currently presented
//   x, y         out  fetch column / row (stage 1)
//   fetch        out  x,y inside the visible area (stage 1)
//   hsync/vsync  out  sync pulses, active level HS_POL / VS_POL (stage 2)
//   de           out  RGB valid (stage 2)
//   line_start   out  pulse with the first de of each visible line
//   frame_start  out  pulse with pixel (0,0)
//   red/green/blue out colour channels, zero whenever de = 0

module vga_timing_gen #(
    parameter int H_VISIBLE  = 305,
    parameter int H_FRONT    = 7,
    parameter int H_SYNC     = 46,
    parameter int H_BACK     = 23,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int COLOR_BITS = 1,
    parameter int CNT_BITS   = 10
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      en,
    input  logic [1:0]                pattern_sel,
    input  logic [3*COLOR_BITS-1:0]   pix_in,
    output logic [CNT_BITS-1:0]       x,
    output logic [CNT_BITS-1:0]       y,
    output logic                      fetch,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic                      line_start,
    output logic                      frame_start,
    output logic [COLOR_BITS-1:0]     red,
    output logic [COLOR_BITS-1:0]     green,
    output logic [COLOR_BITS-1:0]     blue
);

    typedef logic [CNT_BITS-1:0] cnt_t;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS  = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS  = cnt_t'(V_VISIBLE);
    localparam cnt_t H_SS   = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t H_SE   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam cnt_t V_SS   = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t V_SE   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    cnt_t                    r_h;
    cnt_t                    r_v;
    logic                    w_vis;
    logic                    w_hs_act;
    logic                    w_vs_act;
    logic [3*COLOR_BITS-1:0] w_rgb;

    // Raster counters: v advances on the h wrap and wraps itself after the
    // last line, so a frame is exactly H_TOTAL*V_TOTAL enabled clocks.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_h <= '0;
            r_v <= '0;
        end else if (en) begin
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    assign w_vis = (r_h < H_VIS) && (r_v < V_VIS);

    // Stage 1: present the fetch coordinates to the pixel source.
    always_ff @(posedge CLK) begin
        if (RST) begin
            x     <= '0;
            y     <= '0;
            fetch <= 1'b0;
        end else if (en) begin
            x     <= r_h;
            y     <= r_v;
            fetch <= w_vis;
        end
    end

    // Sync regions are decoded from the stage-1 coordinates so that the
    // stage-2 syncs line up with de and RGB without extra delay registers.
    assign w_hs_act = (x >= H_SS) && (x < H_SE);
    assign w_vs_act = (y >= V_SS) && (y < V_SE);

`ifdef VGA_TEST_PATTERN_EN
    localparam int   BAR_W  = H_VISIBLE / 8;
    localparam cnt_t BAR_WC = cnt_t'(BAR_W);
    localparam cnt_t H_HALF = cnt_t'(H_VISIBLE / 2);
    localparam cnt_t V_HALF = cnt_t'(V_VISIBLE / 2);

    logic [1:0] r_pat;
    cnt_t       w_bar_q;
    logic [2:0] w_bar;

    // Pattern changes only take effect at the (0,0) counter state, so the
    // new selection starts exactly with the first pixel of a frame.
    always_ff @(posedge CLK) begin
        if (RST)
            r_pat <= 2'd0;
        else if (en && (r_h == '0) && (r_v == '0))
            r_pat <= pattern_sel;
    end

    // The last bar absorbs the remainder columns of H_VISIBLE/8.
    always_comb begin
        w_bar_q = x / BAR_WC;
        w_bar   = (w_bar_q > cnt_t'(7)) ? 3'd7 : w_bar_q[2:0];
    end

    always_comb begin
        w_rgb = pix_in;
        case (r_pat)
            2'd1: w_rgb = '1;
            2'd2: w_rgb = {{COLOR_BITS{w_bar[2]}}, {COLOR_BITS{w_bar[1]}},
                           {COLOR_BITS{w_bar[0]}}};
            2'd3: begin
                if (x < H_HALF)
                    w_rgb = {{COLOR_BITS{1'b0}}, {COLOR_BITS{1'b1}},
                             {COLOR_BITS{(y < V_HALF)}}};
                else if (x > H_HALF)
                    w_rgb = {{COLOR_BITS{1'b1}}, {(2*COLOR_BITS){1'b0}}};
                else
                    w_rgb = '0;
            end
            default: w_rgb = pix_in;
        endcase
    end
`else
    logic w_unused_sel;
    assign w_unused_sel = ^pattern_sel;
    assign w_rgb        = pix_in;
`endif

    // Stage 2: pixel source output is captured here alongside syncs/strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else if (en) begin
            hsync       <= w_hs_act ? HS_ACT : ~HS_ACT;
            vsync       <= w_vs_act ? VS_ACT : ~VS_ACT;
            de          <= fetch;
            line_start  <= fetch && (x == '0);
            frame_start <= fetch && (x == '0) && (y == '0);
            {red, green, blue} <= fetch ? w_rgb : '0;
        end
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Parametrised VGA raster generator for the iCEBreaker 12 MHz designs; successor to the fixed-timing solid-colour VGA block.
- Generates hsync/vsync with configurable geometry and polarity, data-enable, pixel coordinates and line/frame strobes.
- Outputs per-colour RGB from either an external pixel source or built-in test patterns.
- Sits between the pixel source (framebuffer, sprite logic) and the VGA PMOD pins.

## Interface

- H_VISIBLE, 305, visible clocks per line
- H_FRONT, 7, horizontal front porch clocks
- H_SYNC, 46, hsync pulse clocks
- H_BACK, 23, horizontal back porch clocks
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch lines
- V_SYNC, 2, vsync pulse lines
- V_BACK, 33, vertical back porch lines
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 0, active level of vsync
- COLOR_BITS, 1, bits per colour channel
- CNT_BITS, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- CLK  in  1  pixel clock
- RST  in  1  synchronous, active-high reset
- en  in  1  clock enable for counters and pipeline
- pattern_sel  in  2  0 = pix_in, 1 = white, 2 = colour bars, 3 = quadrants
- pix_in  in  3*COLOR_BITS  {R,G,B} from external source
- x  out  CNT_BITS  fetch column (stage 1)
- y  out  CNT_BITS  fetch row (stage 1)
- fetch  out  1  x,y inside visible area (stage 1)
- hsync, vsync  out  1 each  sync outputs, polarity per HS_POL/VS_POL
- de  out  1  RGB valid (stage 2)
- line_start  out  1  one-cycle pulse with first de of each visible line
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- red, green, blue  out  COLOR_BITS each

## Operation

- H_TOTAL = sum of H_* (381); V_TOTAL = sum of V_* (525).
- h_cnt counts 0..H_TOTAL-1, then wraps to 0.
- v_cnt increments on the h wrap; wraps to 0 after V_TOTAL-1 (no extra line).
- Horizontal regions: visible h < H_VISIBLE; sync active for H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC. Vertical regions are analogous in lines.
- Stage 1 registers x = h_cnt, y = v_cnt, fetch = visible.
- Stage 2 registers hsync, vsync, de = fetch, line_start, frame_start and RGB.
- External source must drive pix_in for (x,y) in the same cycle x,y are presented; pix_in is captured at the next edge.
- RGB is forced to 0 whenever stage-2 de = 0.
- pattern_sel is latched only when counters are at (0,0), so a frame never tears; the latched value resets to 0.

## Timing

- Latency: counter state → x/y/fetch 1 cycle; → hsync/vsync/de/RGB/strobes 2 cycles. All stage-2 outputs are mutually aligned.
- Reset values, next edge after RST=1:
  - counters 0; x=0, y=0; fetch=0; de=0; RGB=0; strobes 0
  - hsync = ~HS_POL, vsync = ~VS_POL
- RST mid-frame behaves the same: no partial line completes; RST takes priority over en.
- en=0 freezes counters, stage 1, stage 2 and the latched pattern; outputs hold their values. Resumes without loss on en=1.
- After RST release with en=1: fetch=1 for (0,0) at cycle 1; de and frame_start at cycle 2.
- hsync period H_TOTAL; vsync period H_TOTAL*V_TOTAL; vsync edges aligned to hsync-period boundaries (h_cnt = 0).

## Configuration

- VGA_TEST_PATTERN_EN defined: pattern_sel is honoured.
  - 1 = all channels all-ones.
  - 2 = 8 vertical bars of width H_VISIBLE/8; bar k = x/(H_VISIBLE/8), clamped to 7; R=k[2], G=k[1], B=k[0], each bit replicated to COLOR_BITS.
  - 3 = quadrants: x < H_VISIBLE/2 → G=1, plus B=1 when y < V_VISIBLE/2; x > H_VISIBLE/2 → R=1; x = H_VISIBLE/2 → black.
- Undefined: pattern_sel is ignored, the pattern logic is not built, and RGB always equals the registered pix_in.

## Test plan

- Defaults, RST 3 cycles then en=1:
  - hsync period 381 clocks, low 46 clocks, falling edge at x=312.
  - Frame period 200025 clocks.
- One full frame: vsync low only during lines 490–491.
  - de high exactly 146400 cycles.
  - frame_start exactly 1 pulse; line_start 480 pulses.
- Macro defined, pattern_sel=2 latched at frame start:
  - x=0..37 → RGB=000; x=38 → 001; x=266..304 → 111.
  - De-asserting pattern_sel mid-frame has no effect until the next frame.
- pattern_sel=0 with pix_in = low bits of x: RGB at each de equals the x presented 1 cycle earlier; RGB=0 outside de.
- Timing and polarity: en=0 for 100 cycles at h_cnt=150, then en=1 → all outputs hold and the line completes with the correct count. Separately, HS_POL=1 → hsync high only for the 46-cycle pulse.
- RST pulse at (200,300):
  - Next cycle: de=0, hsync=1, vsync=1.
  - (0,0) is fetched on the first cycle after release.
